// File: rtl/hamming_mon_pkg.sv
// Shared types for the Hamming(7,4) error monitor: FSM states, error kinds, event record
// and the per-block syndrome decoder.
package hamming_mon_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StScan
    } hem_state_e;

    typedef enum logic {
        ErrData   = 1'b0,
        ErrParity = 1'b1
    } err_kind_e;

    // Block index field is sized for up to 256 blocks; the top slices it down.
    localparam int unsigned MaxBlockW = 8;

    typedef struct packed {
        logic [MaxBlockW-1:0] block;
        err_kind_e            kind;
        logic [1:0]           bit_idx;
        logic [3:0]           nibble;
    } evt_rec_t;

    typedef struct packed {
        logic      valid;
        err_kind_e kind;
        logic [1:0] bit_idx;
    } syn_dec_t;

    function automatic syn_dec_t decode_syn(input logic [2:0] syn);
        syn_dec_t dec;
        dec.valid   = 1'b1;
        dec.kind    = ErrData;
        dec.bit_idx = 2'd0;
        case (syn)
            3'b011: dec.bit_idx = 2'd3;
            3'b101: dec.bit_idx = 2'd2;
            3'b110: dec.bit_idx = 2'd1;
            3'b111: dec.bit_idx = 2'd0;
            3'b001: begin
                dec.kind    = ErrParity;
                dec.bit_idx = 2'd0;
            end
            3'b010: begin
                dec.kind    = ErrParity;
                dec.bit_idx = 2'd1;
            end
            3'b100: begin
                dec.kind    = ErrParity;
                dec.bit_idx = 2'd2;
            end
            default: dec.valid = 1'b0;
        endcase
        return dec;
    endfunction

endpackage

// File: rtl/hem_event_fifo.sv
// First-word-fall-through FIFO of error records. Head fields read as zero while empty;
// push_drop flags a push lost because the FIFO was full with no same-cycle pop.
module hem_event_fifo
    import hamming_mon_pkg::*;
#(
    parameter int unsigned Depth = 8
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  evt_rec_t push_rec,
    input  logic     pop_ready,
    output evt_rec_t head_rec,
    output logic     empty,
    output logic     full,
    output logic     push_drop
);

    localparam int unsigned PtrW = $clog2(Depth);

    logic [PtrW:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW:0] rd_ptr_q, rd_ptr_d;
    logic          do_push, do_pop;
    evt_rec_t      mem_q [Depth];

    always_comb begin
        empty     = (wr_ptr_q == rd_ptr_q);
        full      = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                    (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
        do_pop    = pop_ready && !empty;
        // A pop frees the slot in the same cycle, so a full FIFO still accepts.
        do_push   = push && (!full || do_pop);
        push_drop = push && full && !do_pop;
        wr_ptr_d  = wr_ptr_q + {{PtrW{1'b0}}, do_push};
        rd_ptr_d  = rd_ptr_q + {{PtrW{1'b0}}, do_pop};
        head_rec  = empty ? '0 : mem_q[rd_ptr_q[PtrW-1:0]];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[PtrW-1:0]] <= push_rec;
        end
    end

endmodule

// File: rtl/hamming_error_monitor.sv
// Scans a captured Hamming(7,4) syndrome one block per cycle and queues one record per faulty
// block. Statistics counters are built only when HEM_STATS_EN is defined.
module hamming_error_monitor
    import hamming_mon_pkg::*;
#(
    parameter int unsigned WIDTH       = 128,
    parameter int unsigned BLOCKS      = WIDTH / 4,
    parameter int unsigned PARITY_BITS = BLOCKS * 3,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      chk_valid,
    input  logic [PARITY_BITS-1:0]    syndrome,
    input  logic [WIDTH-1:0]          counter_val,
    output logic                      evt_valid,
    input  logic                      evt_ready,
    output logic [$clog2(BLOCKS)-1:0] evt_block,
    output logic                      evt_kind,
    output logic [1:0]                evt_bit,
    output logic [3:0]                evt_nibble,
    output logic                      scan_busy,
    output logic                      overflow,
    input  logic                      clr_stats,
    output logic [CNT_W-1:0]          data_err_cnt,
    output logic [CNT_W-1:0]          par_err_cnt
);

    localparam int unsigned IdxW = $clog2(BLOCKS);

    hem_state_e              state_q, state_d;
    logic [IdxW-1:0]         idx_q, idx_d;
    logic [BLOCKS-1:0][2:0]  shadow_syn_q, shadow_syn_d;
    logic [BLOCKS-1:0][3:0]  shadow_val_q, shadow_val_d;
    logic [PARITY_BITS-1:0]  last_syn_q, last_syn_d;
    logic                    scan_busy_q, scan_busy_d;
    logic                    overflow_q, overflow_d;

    syn_dec_t cur_dec;
    evt_rec_t push_rec;
    evt_rec_t head_rec;
    logic     push;
    logic     fifo_empty;
    logic     fifo_full;
    logic     push_drop;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        shadow_syn_d = shadow_syn_q;
        shadow_val_d = shadow_val_q;
        last_syn_d   = last_syn_q;
        unique case (state_q)
            StIdle: begin
                // Dropping chk_valid closes the window so a held syndrome may rescan later.
                if (!chk_valid) begin
                    last_syn_d = '0;
                end else if (|syndrome && (syndrome != last_syn_q)) begin
                    state_d      = StScan;
                    shadow_syn_d = syndrome;
                    shadow_val_d = counter_val;
                    last_syn_d   = syndrome;
                    idx_d        = '0;
                end
            end
            StScan: begin
                idx_d = idx_q + IdxW'(1);
                if (idx_q == IdxW'(BLOCKS - 1)) begin
                    state_d = StIdle;
                    idx_d   = '0;
                end
            end
            default: state_d = StIdle;
        endcase
        scan_busy_d = (state_d == StScan);
    end

    always_comb begin
        cur_dec          = decode_syn(shadow_syn_q[idx_q]);
        push             = (state_q == StScan) && cur_dec.valid;
        push_rec.block   = MaxBlockW'(idx_q);
        push_rec.kind    = cur_dec.kind;
        push_rec.bit_idx = cur_dec.bit_idx;
        push_rec.nibble  = shadow_val_q[idx_q];
        overflow_d       = clr_stats ? 1'b0 : (overflow_q | push_drop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            shadow_syn_q <= '0;
            shadow_val_q <= '0;
            last_syn_q   <= '0;
            scan_busy_q  <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            shadow_syn_q <= shadow_syn_d;
            shadow_val_q <= shadow_val_d;
            last_syn_q   <= last_syn_d;
            scan_busy_q  <= scan_busy_d;
            overflow_q   <= overflow_d;
        end
    end

    hem_event_fifo #(
        .Depth(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_rec  (push_rec),
        .pop_ready (evt_ready),
        .head_rec  (head_rec),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .push_drop (push_drop)
    );

    assign evt_valid  = !fifo_empty;
    assign evt_block  = head_rec.block[IdxW-1:0];
    assign evt_kind   = head_rec.kind;
    assign evt_bit    = head_rec.bit_idx;
    assign evt_nibble = head_rec.nibble;
    assign scan_busy  = scan_busy_q;
    assign overflow   = overflow_q;

    logic unused_sig;
    assign unused_sig = ^{fifo_full, head_rec.block[MaxBlockW-1:IdxW]};

`ifdef HEM_STATS_EN
    logic [CNT_W-1:0] data_cnt_q, data_cnt_d;
    logic [CNT_W-1:0] par_cnt_q, par_cnt_d;

    // Every decoded error counts, whether the FIFO kept the record or not.
    always_comb begin
        data_cnt_d = data_cnt_q;
        par_cnt_d  = par_cnt_q;
        if (clr_stats) begin
            data_cnt_d = '0;
            par_cnt_d  = '0;
        end else if (push) begin
            if (cur_dec.kind == ErrData) begin
                if (data_cnt_q != '1) data_cnt_d = data_cnt_q + CNT_W'(1);
            end else begin
                if (par_cnt_q != '1) par_cnt_d = par_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_cnt_q <= '0;
            par_cnt_q  <= '0;
        end else begin
            data_cnt_q <= data_cnt_d;
            par_cnt_q  <= par_cnt_d;
        end
    end

    assign data_err_cnt = data_cnt_q;
    assign par_err_cnt  = par_cnt_q;
`else
    assign data_err_cnt = '0;
    assign par_err_cnt  = '0;
`endif

endmodule

// File: tb/tb_hamming_error_monitor.sv
// Directed and randomized checks of hamming_error_monitor against a queue-based record model.
module tb_hamming_error_monitor;

    localparam int Depth = 8;

    logic         clk;
    logic         rst;
    logic         chk_valid;
    logic [95:0]  syndrome;
    logic [127:0] counter_val;
    logic         evt_ready;
    logic         clr_stats;

    logic         evt_valid, evt_kind, scan_busy, overflow;
    logic [4:0]   evt_block;
    logic [1:0]   evt_bit;
    logic [3:0]   evt_nibble;
    logic [15:0]  data_err_cnt, par_err_cnt;

    logic         s_evt_valid, s_evt_kind, s_scan_busy, s_overflow;
    logic [4:0]   s_evt_block;
    logic [1:0]   s_evt_bit;
    logic [3:0]   s_evt_nibble;
    logic [3:0]   s_data_cnt, s_par_cnt;

    int checks = 0;
    int errors = 0;

    logic [11:0] exp_q[$];
    int          exp_data = 0;
    int          exp_par  = 0;
    logic        exp_ovf  = 1'b0;
    logic [11:0] mon_got;

    hamming_error_monitor u_dut (
        .clk(clk), .rst(rst), .chk_valid(chk_valid), .syndrome(syndrome),
        .counter_val(counter_val), .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_block(evt_block), .evt_kind(evt_kind), .evt_bit(evt_bit),
        .evt_nibble(evt_nibble), .scan_busy(scan_busy), .overflow(overflow),
        .clr_stats(clr_stats), .data_err_cnt(data_err_cnt), .par_err_cnt(par_err_cnt)
    );

    hamming_error_monitor #(.CNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .chk_valid(chk_valid), .syndrome(syndrome),
        .counter_val(counter_val), .evt_valid(s_evt_valid), .evt_ready(evt_ready),
        .evt_block(s_evt_block), .evt_kind(s_evt_kind), .evt_bit(s_evt_bit),
        .evt_nibble(s_evt_nibble), .scan_busy(s_scan_busy), .overflow(s_overflow),
        .clr_stats(clr_stats), .data_err_cnt(s_data_cnt), .par_err_cnt(s_par_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sat(input int c, input int w);
`ifdef HEM_STATS_EN
        int mx;
        mx = (1 << w) - 1;
        return (c > mx) ? mx : c;
`else
        return 0;
`endif
    endfunction

    task automatic chk_stats(input string tag);
        chk({tag, "_data_cnt"}, 32'(data_err_cnt), sat(exp_data, 16));
        chk({tag, "_par_cnt"}, 32'(par_err_cnt), sat(exp_par, 16));
        chk({tag, "_sat_data_cnt"}, 32'(s_data_cnt), sat(exp_data, 4));
        chk({tag, "_sat_par_cnt"}, 32'(s_par_cnt), sat(exp_par, 4));
        chk({tag, "_overflow"}, 32'(overflow), 32'(exp_ovf));
    endtask

    // Hamming position view: syndrome value names the flipped codeword position.
    task automatic model_scan(input logic [95:0] syn, input logic [127:0] val,
                              input logic ready);
        int data_bit_at_pos[8];
        data_bit_at_pos = '{0, 0, 0, 3, 0, 2, 1, 0};
        for (int b = 0; b < 32; b++) begin
            int pos;
            logic kind;
            int bidx;
            pos = int'(syn[b*3 +: 3]);
            if (pos != 0) begin
                if ((pos & (pos - 1)) == 0) begin
                    kind = 1'b1;
                    bidx = $clog2(pos);
                    exp_par++;
                end else begin
                    kind = 1'b0;
                    bidx = data_bit_at_pos[pos];
                    exp_data++;
                end
                if (ready || exp_q.size() < Depth)
                    exp_q.push_back({5'(b), kind, 2'(bidx), val[b*4 +: 4]});
                else
                    exp_ovf = 1'b1;
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst && evt_valid && evt_ready) begin
            mon_got = {evt_block, evt_kind, evt_bit, evt_nibble};
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_record observed=%h expected=none", mon_got);
            end
            if (exp_q.size() != 0) begin
                chk("record", 32'(mon_got), 32'(exp_q[0]));
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic run_scan(input logic [95:0] syn, input logic [127:0] val,
                            input string tag);
        int busy;
        chk_valid   = 1'b1;
        syndrome    = syn;
        counter_val = val;
        model_scan(syn, val, evt_ready);
        @(posedge clk); #1;
        busy = 0;
        while (scan_busy && busy < 100) begin
            busy++;
            @(posedge clk); #1;
        end
        chk({tag, "_busy_cycles"}, busy, 32);
        repeat (3) begin @(posedge clk); #1; end
        if (evt_ready) chk({tag, "_drained"}, exp_q.size(), 0);
        chk_stats(tag);
    endtask

    task automatic drain(input string tag);
        evt_ready = 1'b1;
        repeat (12) begin @(posedge clk); #1; end
        chk({tag, "_drain_empty"}, exp_q.size(), 0);
        chk({tag, "_drain_valid"}, 32'(evt_valid), 0);
    endtask

    function automatic logic [127:0] rand_val();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        logic [95:0]  s;
        logic [127:0] v;
        int           cnt;

        rst = 1'b1; chk_valid = 1'b0; syndrome = '0; counter_val = '0;
        evt_ready = 1'b1; clr_stats = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("reset_evt_valid", 32'(evt_valid), 0);
        chk("reset_evt_fields", {evt_block, evt_kind, evt_bit, evt_nibble}, 0);
        chk("reset_scan_busy", 32'(scan_busy), 0);
        chk_stats("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Single data error in block 0.
        s = '0; s[2:0] = 3'b011;
        v = rand_val(); v[3:0] = 4'hA;
        run_scan(s, v, "t1");

        // Parity errors at both ends of the vector.
        s = '0; s[5*3 +: 3] = 3'b001; s[31*3 +: 3] = 3'b100;
        run_scan(s, rand_val(), "t2");

        // Held syndrome scans once; a one-cycle gap in chk_valid re-arms it.
        s = '0; s[3*3 +: 3] = 3'b010; s[9*3 +: 3] = 3'b110;
        v = rand_val();
        run_scan(s, v, "t3a");
        cnt = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (scan_busy) cnt++;
        end
        chk("t3_held_no_rescan", cnt, 0);
        chk_valid = 1'b0;
        @(posedge clk); #1;
        run_scan(s, v, "t3b");

        // Consumer stalled, every block faulty: FIFO keeps the first Depth records.
        evt_ready = 1'b0;
        s = '0;
        for (int b = 0; b < 32; b++) s[b*3 +: 3] = 3'b111;
        run_scan(s, rand_val(), "t4");
        chk("t4_evt_valid", 32'(evt_valid), 1);
        drain("t4");

        // clr_stats collides with the block-0 increment.
        s = '0; s[2:0] = 3'b011;
        v = rand_val();
        chk_valid = 1'b1; syndrome = s; counter_val = v;
        model_scan(s, v, evt_ready);
        @(posedge clk); #1;
        clr_stats = 1'b1;
        @(posedge clk); #1;
        clr_stats = 1'b0;
        exp_data = 0; exp_par = 0; exp_ovf = 1'b0;
        cnt = 0;
        while (scan_busy && cnt < 100) begin
            cnt++;
            @(posedge clk); #1;
        end
        repeat (3) begin @(posedge clk); #1; end
        chk("t6_drained", exp_q.size(), 0);
        chk_stats("t6");

        // Randomized scans, some with the consumer stalled.
        for (int it = 0; it < 6; it++) begin
            do begin
                s = '0;
                for (int b = 0; b < 32; b++)
                    if ($urandom_range(3) == 0) s[b*3 +: 3] = 3'($urandom_range(7, 1));
            end while (s == '0 || s == syndrome);
            evt_ready = (it % 3 != 2);
            run_scan(s, rand_val(), "rand");
            if (!evt_ready) drain("rand");
        end

        // Asynchronous reset in the middle of a scan.
        evt_ready = 1'b0;
        s = '0;
        for (int b = 0; b < 32; b++) s[b*3 +: 3] = 3'b101;
        v = rand_val();
        chk_valid = 1'b1; syndrome = s; counter_val = v;
        @(posedge clk); #1;
        repeat (10) begin @(posedge clk); #1; end
        chk("t5_pre_busy", 32'(scan_busy), 1);
        rst = 1'b1;
        #1;
        exp_q.delete();
        exp_data = 0; exp_par = 0; exp_ovf = 1'b0;
        chk("t5_evt_valid", 32'(evt_valid), 0);
        chk("t5_scan_busy", 32'(scan_busy), 0);
        chk("t5_evt_fields", {evt_block, evt_kind, evt_bit, evt_nibble}, 0);
        chk_stats("t5");
        chk_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        evt_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        chk("t5_post_busy", 32'(scan_busy), 0);
        chk("t5_post_valid", 32'(evt_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

endmodule
